// File: rtl/pipe_stage_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_pkg
//
// Shared definitions for the pipeline-boundary buffer (pipe_stage_buf) and
// its per-slice controller (pipe_slice).
//
// Contents:
//   slice_state_e   per-slice occupancy state (EMPTY / FULL / SKID)
//   occ_w()         width of the occupancy counter for a given depth
//   PIPE_MEM_WB_W   payload width of the MEM/WB boundary (104 bits)
//   MEM_WB_*        LSB offsets and widths of each MEM/WB field
//   mem_wb_t        field view of the MEM/WB payload
//   pack_mem_wb()   producer-side packing of the MEM/WB fields
//   unpack_mem_wb() consumer-side unpacking of the MEM/WB fields
// ---------------------------------------------------------------------------
package pipe_stage_pkg;

    // SKID is only reachable when the skid register is built in.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } slice_state_e;

    // Sized for the skid build (2*depth entries) so both builds share one
    // port width.
    function automatic int occ_w(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

    localparam int PIPE_MEM_WB_W = 104;

    // MEM/WB layout, LSB first:
    // RegWrite | WDSel | data | aluout | rd | PC
    localparam int MEM_WB_REGWRITE_LSB = 0;
    localparam int MEM_WB_REGWRITE_W   = 1;
    localparam int MEM_WB_WDSEL_LSB    = 1;
    localparam int MEM_WB_WDSEL_W      = 2;
    localparam int MEM_WB_DATA_LSB     = 3;
    localparam int MEM_WB_DATA_W       = 32;
    localparam int MEM_WB_ALUOUT_LSB   = 35;
    localparam int MEM_WB_ALUOUT_W     = 32;
    localparam int MEM_WB_RD_LSB       = 67;
    localparam int MEM_WB_RD_W         = 5;
    localparam int MEM_WB_PC_LSB       = 72;
    localparam int MEM_WB_PC_W         = 32;

    typedef struct packed {
        logic [MEM_WB_PC_W-1:0]       pc;
        logic [MEM_WB_RD_W-1:0]       rd;
        logic [MEM_WB_ALUOUT_W-1:0]   aluout;
        logic [MEM_WB_DATA_W-1:0]     data;
        logic [MEM_WB_WDSEL_W-1:0]    wdsel;
        logic [MEM_WB_REGWRITE_W-1:0] regwrite;
    } mem_wb_t;

    function automatic logic [PIPE_MEM_WB_W-1:0] pack_mem_wb(
        input logic [MEM_WB_PC_W-1:0]       pc,
        input logic [MEM_WB_RD_W-1:0]       rd,
        input logic [MEM_WB_ALUOUT_W-1:0]   aluout,
        input logic [MEM_WB_DATA_W-1:0]     data,
        input logic [MEM_WB_WDSEL_W-1:0]    wdsel,
        input logic [MEM_WB_REGWRITE_W-1:0] regwrite
    );
        logic [PIPE_MEM_WB_W-1:0] p;
        p = '0;
        p[MEM_WB_PC_LSB       +: MEM_WB_PC_W]       = pc;
        p[MEM_WB_RD_LSB       +: MEM_WB_RD_W]       = rd;
        p[MEM_WB_ALUOUT_LSB   +: MEM_WB_ALUOUT_W]   = aluout;
        p[MEM_WB_DATA_LSB     +: MEM_WB_DATA_W]     = data;
        p[MEM_WB_WDSEL_LSB    +: MEM_WB_WDSEL_W]    = wdsel;
        p[MEM_WB_REGWRITE_LSB +: MEM_WB_REGWRITE_W] = regwrite;
        return p;
    endfunction

    function automatic mem_wb_t unpack_mem_wb(input logic [PIPE_MEM_WB_W-1:0] p);
        mem_wb_t f;
        f.pc       = p[MEM_WB_PC_LSB       +: MEM_WB_PC_W];
        f.rd       = p[MEM_WB_RD_LSB       +: MEM_WB_RD_W];
        f.aluout   = p[MEM_WB_ALUOUT_LSB   +: MEM_WB_ALUOUT_W];
        f.data     = p[MEM_WB_DATA_LSB     +: MEM_WB_DATA_W];
        f.wdsel    = p[MEM_WB_WDSEL_LSB    +: MEM_WB_WDSEL_W];
        f.regwrite = p[MEM_WB_REGWRITE_LSB +: MEM_WB_REGWRITE_W];
        return f;
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// ---------------------------------------------------------------------------
// pipe_slice
//
// One register slice of the pipeline-boundary buffer: a small FSM plus the
// main payload register (and, in the skid build, a skid register).
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> EMPTY/FULL/SKID, in_ready decoded from
//                                    state only (no path from out_ready)
//                       undefined -> EMPTY/FULL, in_ready passes out_ready
//                                    through combinationally
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous reset, active-low
//   flush      synchronous kill of the held entries
//   in_valid   upstream has payload
//   in_ready   slice accepts payload this cycle
//   in_data    upstream payload
//   out_valid  slice presents payload
//   out_ready  downstream accepts payload this cycle
//   out_data   presented payload (main register)
// ---------------------------------------------------------------------------
module pipe_slice
    import pipe_stage_pkg::*;
#(
    parameter int WIDTH = 104
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    slice_state_e     state;
    logic [WIDTH-1:0] main_q;
    logic             in_fire;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_q;

    // Pure decode of the state register, so ready never depends on the
    // downstream consumer in the same cycle.
    assign in_ready = (state != SKID);
`else
    // Without a skid register a full slice can only take new data when its
    // current entry leaves in the same cycle.
    assign in_ready = (state == EMPTY) || out_ready;
`endif

    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;

    // The main register always holds the oldest entry; the skid register
    // only catches the one that arrives while the main entry is stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= EMPTY;
            main_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_q <= '0;
`endif
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= FULL;
                        main_q <= in_data;
                    end
                end
                FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (in_fire && !out_ready) begin
                        state  <= SKID;
                        skid_q <= in_data;
                    end else if (in_fire) begin
                        main_q <= in_data;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
`else
                    if (in_fire) begin
                        main_q <= in_data;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                SKID: begin
                    if (out_ready) begin
                        state  <= FULL;
                        main_q <= skid_q;
                    end
                end
`endif
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Pipeline-boundary buffer: carries an opaque WIDTH-bit payload through DEPTH
// register slices with a valid/ready handshake, a synchronous flush and an
// occupancy count. Order is FIFO; nothing is lost or duplicated.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> each slice has a skid register,
//                                    capacity 2*DEPTH, registered in_ready
//                       undefined -> capacity DEPTH, in_ready follows
//                                    out_ready combinationally
//
// Parameters:
//   WIDTH   payload bits (104 = MEM/WB packing, see pipe_stage_pkg)
//   DEPTH   register slices in series, >= 1
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous reset, active-low (0 = reset)
//   flush      synchronous kill of every buffered entry
//   in_valid   producer has payload
//   in_ready   buffer accepts payload this cycle
//   in_data    producer payload
//   out_valid  buffer presents payload
//   out_ready  consumer accepts payload this cycle
//   out_data   payload to consumer
//   occ        entries held, occ_w(DEPTH) bits
// ---------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_stage_pkg::*;
#(
    parameter int WIDTH = 104,
    parameter int DEPTH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [occ_w(DEPTH)-1:0]  occ
);

    localparam int               OCC_W   = occ_w(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    logic accept_en;
    logic in_fire;
    logic out_fire;

    // Nothing may enter while held in reset or during a flush cycle.
    assign accept_en = reset && !flush;

    // Each slice keeps its handshake signals inside its own generate scope,
    // so the ready chain is a series of distinct nets rather than one
    // self-referencing array.
    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             dn_ready;
        logic             s_in_ready;
        logic             s_out_valid;
        logic [WIDTH-1:0] s_out_data;

        if (k == 0) begin : g_head
            assign up_valid = in_valid && accept_en;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = g_slice[k-1].s_out_valid;
            assign up_data  = g_slice[k-1].s_out_data;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_link
            assign dn_ready = g_slice[k+1].s_in_ready;
        end

        pipe_slice #(
            .WIDTH (WIDTH)
        ) u_slice (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (up_valid),
            .in_ready  (s_in_ready),
            .in_data   (up_data),
            .out_valid (s_out_valid),
            .out_ready (dn_ready),
            .out_data  (s_out_data)
        );
    end

    assign in_ready  = g_slice[0].s_in_ready && accept_en;
    assign out_valid = g_slice[DEPTH-1].s_out_valid;
    assign out_data  = g_slice[DEPTH-1].s_out_data;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Occupancy tracks the handshakes at the two ends; a simultaneous push
    // and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            occ <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Three buffers (DEPTH 1 at WIDTH 104, DEPTH 2 and DEPTH 3 at WIDTH 16) share
// one stimulus stream. A queue-per-slice model predicts every output of every
// buffer each cycle; directed phases add literal expectations on top.
// Honours PIPE_STAGE_SKID_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;
    import pipe_stage_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
    localparam int SLICE_CAP = 2;
    localparam bit SKID_BUILD = 1'b1;
`else
    localparam int SLICE_CAP = 1;
    localparam bit SKID_BUILD = 1'b0;
`endif
    localparam int NDUT = 3;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [103:0] in_data;

    logic         in_ready1, out_valid1;
    logic [103:0] out_data1;
    logic [1:0]   occ1;
    logic         in_ready2, out_valid2;
    logic [15:0]  out_data2;
    logic [2:0]   occ2;
    logic         in_ready3, out_valid3;
    logic [15:0]  out_data3;
    logic [2:0]   occ3;

    int checks;
    int errors;

    pipe_stage_buf #(.WIDTH(104), .DEPTH(1)) dut_d1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occ(occ1)
    );

    pipe_stage_buf #(.WIDTH(16), .DEPTH(2)) dut_d2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data[15:0]),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occ(occ2)
    );

    pipe_stage_buf #(.WIDTH(16), .DEPTH(3)) dut_d3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data[15:0]),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .occ(occ3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Uniform views of the three buffers, index d has DEPTH d+1.
    logic         dv [NDUT];
    logic         dr [NDUT];
    logic [103:0] dq [NDUT];
    int           docc [NDUT];

    assign dv[0] = out_valid1;
    assign dv[1] = out_valid2;
    assign dv[2] = out_valid3;
    assign dr[0] = in_ready1;
    assign dr[1] = in_ready2;
    assign dr[2] = in_ready3;
    assign dq[0] = out_data1;
    assign dq[1] = {88'd0, out_data2};
    assign dq[2] = {88'd0, out_data3};
    assign docc[0] = int'(occ1);
    assign docc[1] = int'(occ2);
    assign docc[2] = int'(occ3);

    // Model: each slice is a small queue (front = presented entry).
    int           mcnt [NDUT][3];
    logic [103:0] mdat [NDUT][3][2];
    int           macc [NDUT];
    bit           prev_stall [NDUT];
    logic [103:0] prev_data [NDUT];

    function automatic logic [103:0] width_mask(input int d);
        return (d == 0) ? {104{1'b1}} : {88'd0, 16'hFFFF};
    endfunction

    // A slice can take an entry if it has room, or (no skid register) if
    // its only entry leaves this cycle.
    function automatic bit slice_ready(input int d, input int k);
        bit r;
        r = out_ready;
        for (int j = d; j >= k; j--) begin
            if (SKID_BUILD) r = (mcnt[d][j] < 2);
            else            r = (mcnt[d][j] == 0) || r;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [103:0] actual,
                               input logic [103:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkCycle();
        for (int d = 0; d < NDUT; d++) begin
            int           occ_sum;
            bit           ev;
            logic [103:0] ed;
            occ_sum = 0;
            for (int k = 0; k <= d; k++) occ_sum += mcnt[d][k];
            ev = (mcnt[d][d] > 0);
            ed = mdat[d][d][0];
            checkOutput($sformatf("d%0d_out_valid", d + 1), 104'(dv[d]), 104'(ev));
            if (ev) checkOutput($sformatf("d%0d_out_data", d + 1), dq[d], ed);
            checkOutput($sformatf("d%0d_in_ready", d + 1), 104'(dr[d]),
                        104'(slice_ready(d, 0) && reset && !flush));
            checkOutput($sformatf("d%0d_occ", d + 1), 104'(docc[d]), 104'(occ_sum));
            checkOutput($sformatf("d%0d_occ_le_cap", d + 1),
                        104'(docc[d] <= (d + 1) * SLICE_CAP), 104'(1));
            if (prev_stall[d] && dv[d])
                checkOutput($sformatf("d%0d_stall_stable", d + 1), dq[d], prev_data[d]);
            prev_stall[d] = dv[d] && !out_ready && reset && !flush;
            prev_data[d]  = dq[d];
        end
    endtask

    task automatic modelStep();
        for (int d = 0; d < NDUT; d++) begin
            bit           fire [4];
            logic [103:0] mv   [4];
            if (!reset || flush) begin
                for (int k = 0; k < 3; k++) mcnt[d][k] = 0;
            end else begin
                for (int k = 0; k <= d; k++) begin
                    bit up_valid;
                    up_valid = (k == 0) ? in_valid : (mcnt[d][k-1] > 0);
                    fire[k]  = up_valid && slice_ready(d, k);
                    mv[k]    = (k == 0) ? (in_data & width_mask(d)) : mdat[d][k-1][0];
                end
                fire[d+1] = (mcnt[d][d] > 0) && out_ready;
                if (fire[0]) macc[d]++;
                for (int k = 0; k <= d; k++) begin
                    if (fire[k+1]) begin
                        mdat[d][k][0] = mdat[d][k][1];
                        mcnt[d][k]--;
                    end
                end
                for (int k = 0; k <= d; k++) begin
                    if (fire[k]) begin
                        mdat[d][k][mcnt[d][k]] = mv[k];
                        mcnt[d][k]++;
                    end
                end
            end
        end
    endtask

    // Drives inputs mid-cycle and compares every buffer against the model.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic [103:0] id, input logic ordy);
        @(negedge clk);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        checkCycle();
    endtask

    task automatic advance();
        @(posedge clk);
        modelStep();
    endtask

    initial begin
        int           acc;
        int           got;
        int           cyc;
        logic [103:0] pkt;
        logic [127:0] rnd;

        checks = 0;
        errors = 0;
        for (int d = 0; d < NDUT; d++) begin
            macc[d] = 0;
            prev_stall[d] = 1'b0;
            prev_data[d] = '0;
            for (int k = 0; k < 3; k++) begin
                mcnt[d][k] = 0;
                mdat[d][k][0] = '0;
                mdat[d][k][1] = '0;
            end
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 104'hAB; out_ready = 1'b1;
        advance();

        $display("[TB] reset behaviour");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 104'hAB, 1'b1);
            checkOutput("t1_out_valid", 104'(out_valid2), 104'(0));
            checkOutput("t1_out_data", 104'(out_data2), 104'(0));
            checkOutput("t1_out_data_d1", out_data1, 104'(0));
            checkOutput("t1_occ", 104'(occ2), 104'(0));
            checkOutput("t1_in_ready", 104'(in_ready2), 104'(0));
            advance();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 104'(0), 1'b1);
        advance();
        applyStimulus(1'b1, 1'b0, 1'b0, 104'(0), 1'b1);
        checkOutput("t1_in_ready_after", 104'(in_ready2), 104'(1));
        advance();

        $display("[TB] streaming");
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 104'(i), 1'b1);
            if (i == 2) checkOutput("t2_not_yet", 104'(out_valid2), 104'(0));
            if (i >= 3) begin
                checkOutput("t2_valid", 104'(out_valid2), 104'(1));
                checkOutput("t2_data", 104'(out_data2), 104'(i - 2));
                checkOutput("t2_occ", 104'(occ2), 104'(2));
            end
            advance();
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 104'(0), 1'b1);
            advance();
        end

        $display("[TB] backpressure fill and drain");
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 104'(16'hA0 + i), 1'b0);
            if (in_ready2) acc++;
            advance();
        end
        checkOutput("t3_accepted", 104'(acc), 104'(2 * SLICE_CAP));
        got = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 104'(0), 1'b1);
            if (out_valid2) begin
                checkOutput("t3_order", 104'(out_data2), 104'(16'hA0 + got));
                got++;
            end
            advance();
        end
        checkOutput("t3_drained", 104'(got), 104'(2 * SLICE_CAP));

        $display("[TB] flush");
        applyStimulus(1'b1, 1'b0, 1'b1, 104'h11, 1'b0);
        advance();
        applyStimulus(1'b1, 1'b0, 1'b1, 104'h22, 1'b0);
        advance();
        applyStimulus(1'b1, 1'b1, 1'b1, 104'h33, 1'b1);
        checkOutput("t4_flush_valid", 104'(out_valid2), 104'(1));
        checkOutput("t4_flush_data", 104'(out_data2), 104'h11);
        checkOutput("t4_flush_in_ready", 104'(in_ready2), 104'(0));
        advance();
        applyStimulus(1'b1, 1'b0, 1'b0, 104'(0), 1'b1);
        checkOutput("t4_after_valid", 104'(out_valid2), 104'(0));
        checkOutput("t4_after_occ", 104'(occ2), 104'(0));
        for (int i = 0; i < 4; i++) begin
            advance();
            applyStimulus(1'b1, 1'b0, 1'b0, 104'(0), 1'b1);
            checkOutput("t4_no_ghost", 104'(out_valid2), 104'(0));
        end
        advance();

        $display("[TB] MEM/WB payload");
        pkt = pack_mem_wb(32'h00000040, 5'd5, 32'hDEADBEEF, 32'h12345678, 2'd2, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, pkt, 1'b1);
        advance();
        applyStimulus(1'b1, 1'b0, 1'b0, 104'(0), 1'b1);
        checkOutput("t6_valid", 104'(out_valid1), 104'(1));
        checkOutput("t6_pc", 104'(out_data1[103:72]), 104'(32'h00000040));
        checkOutput("t6_rd", 104'(out_data1[71:67]), 104'(5));
        checkOutput("t6_aluout", 104'(out_data1[66:35]), 104'(32'hDEADBEEF));
        checkOutput("t6_data", 104'(out_data1[34:3]), 104'(32'h12345678));
        checkOutput("t6_wdsel", 104'(out_data1[2:1]), 104'(2));
        checkOutput("t6_regwrite", 104'(out_data1[0]), 104'(1));
        advance();

        $display("[TB] random traffic");
        for (int d = 0; d < NDUT; d++) macc[d] = 0;
        cyc = 0;
        while ((macc[0] < 10000 || macc[2] < 10000) && cyc < 60000) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(1'b1, 1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                          rnd[103:0], 1'($urandom_range(0, 1)));
            advance();
            cyc++;
        end
        checkOutput("t5_items_d1", 104'(macc[0] >= 10000), 104'(1));
        checkOutput("t5_items_d3", 104'(macc[2] >= 10000), 104'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
